// File: rtl/snake_dir_pkg.sv
// Shared types and constants for the snake direction queue: directions, PS/2 prefixes,
// per-player scancodes and the parser state type.
package snake_dir_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Player 0: numeric keypad 8/6/5/4
  localparam logic [7:0] P0_UP    = 8'h75;
  localparam logic [7:0] P0_RIGHT = 8'h74;
  localparam logic [7:0] P0_DOWN  = 8'h73;
  localparam logic [7:0] P0_LEFT  = 8'h6B;

  // Player 0 arrow keys, only meaningful after an 0xE0 prefix
  localparam logic [7:0] ARROW_UP    = 8'h75;
  localparam logic [7:0] ARROW_RIGHT = 8'h74;
  localparam logic [7:0] ARROW_DOWN  = 8'h72;
  localparam logic [7:0] ARROW_LEFT  = 8'h6B;

  // Player 1: W/D/S/A
  localparam logic [7:0] P1_UP    = 8'h1D;
  localparam logic [7:0] P1_RIGHT = 8'h23;
  localparam logic [7:0] P1_DOWN  = 8'h1B;
  localparam logic [7:0] P1_LEFT  = 8'h1C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Per-player turn FIFO: filters candidates against the tail (or current direction),
// buffers accepted turns and applies one per step pulse.
module snake_dir_fifo
  import snake_dir_pkg::*;
#(
  parameter int   QUEUE_DEPTH = 2,
  parameter dir_t RESET_DIR   = DIR_UP,
  parameter int   CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dir_t          push_dir,
  input  logic          pop,
  output dir_t          direction,
  output logic [CW-1:0] count,
  output logic          dropped
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  dir_t          mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail_ptr;
  dir_t          ref_dir;
  logic          empty;
  logic          full;
  logic          accept;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The reference is the most recently queued turn, so a burst of keys is
  // judged against where the snake will be heading, not where it is now.
  always_comb begin
    tail_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PW'(1);
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    ref_dir  = empty ? direction : mem[tail_ptr];
    accept   = push && (push_dir != ref_dir) && (push_dir != opposite(ref_dir));
    do_pop   = pop && !empty;
    do_push  = accept && (!full || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      direction <= RESET_DIR;
      dropped   <= 1'b0;
    end else begin
      dropped <= accept && full && !do_pop;
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) begin
        rd_ptr    <= next_ptr(rd_ptr);
        direction <= mem[rd_ptr];
      end
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dir;
  end

endmodule

// File: rtl/snake_dir_queue.sv
// PS/2 byte-stream parser and keymap decode feeding one turn FIFO per player.
// Define SNAKE_ARROW_KEYS_EN to map E0-prefixed arrow keys onto player 0.
module snake_dir_queue
  import snake_dir_pkg::*;
#(
  parameter int                       NUM_PLAYERS = 1,
  parameter int                       QUEUE_DEPTH = 2,
  parameter logic [2*NUM_PLAYERS-1:0] RESET_DIRS  = '0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [7:0]                                     scancode,
  input  logic                                           scancode_valid,
  input  logic                                           step,
  output logic [2*NUM_PLAYERS-1:0]                       direction,
  output logic [NUM_PLAYERS*$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic [NUM_PLAYERS-1:0]                         turn_dropped
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  parse_state_t state_q;
  parse_state_t state_d;
  logic         make_valid;
  logic         make_ext;

  // Returns {hit, dir} for the given player.
  function automatic logic [2:0] decode_key(input int player, input logic ext,
                                            input logic [7:0] code);
    logic [2:0] k;
    k = '0;
    if (ext) begin
`ifdef SNAKE_ARROW_KEYS_EN
      if (player == 0) begin
        case (code)
          ARROW_UP:    k = {1'b1, DIR_UP};
          ARROW_RIGHT: k = {1'b1, DIR_RIGHT};
          ARROW_DOWN:  k = {1'b1, DIR_DOWN};
          ARROW_LEFT:  k = {1'b1, DIR_LEFT};
          default:     k = '0;
        endcase
      end
`else
      k = '0;
`endif
    end else if (player == 0) begin
      case (code)
        P0_UP:    k = {1'b1, DIR_UP};
        P0_RIGHT: k = {1'b1, DIR_RIGHT};
        P0_DOWN:  k = {1'b1, DIR_DOWN};
        P0_LEFT:  k = {1'b1, DIR_LEFT};
        default:  k = '0;
      endcase
    end else if (player == 1) begin
      case (code)
        P1_UP:    k = {1'b1, DIR_UP};
        P1_RIGHT: k = {1'b1, DIR_RIGHT};
        P1_DOWN:  k = {1'b1, DIR_DOWN};
        P1_LEFT:  k = {1'b1, DIR_LEFT};
        default:  k = '0;
      endcase
    end
    return k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Break codes (with or without E0) are swallowed; only make bytes reach decode.
  always_comb begin
    state_d    = state_q;
    make_valid = 1'b0;
    make_ext   = 1'b0;
    if (scancode_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scancode == PS2_EXT)      state_d = ST_EXT;
          else if (scancode == PS2_BRK) state_d = ST_BRK;
          else                          make_valid = 1'b1;
        end
        ST_BRK: state_d = ST_IDLE;
        ST_EXT: begin
          if (scancode == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_valid = 1'b1;
            make_ext   = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [2:0] key;
    always_comb key = decode_key(p, make_ext, scancode);

    snake_dir_fifo #(
      .QUEUE_DEPTH(QUEUE_DEPTH),
      .RESET_DIR  (RESET_DIRS[2*p +: 2]),
      .CW         (CW)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (make_valid & key[2]),
      .push_dir (key[1:0]),
      .pop      (step),
      .direction(direction[2*p +: 2]),
      .count    (queue_count[CW*p +: CW]),
      .dropped  (turn_dropped[p])
    );
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue with two players and two-deep queues; an independent
// model predicts every cycle's outputs into a scoreboard queue.
module tb_snake_dir_queue;

  localparam int         NP       = 2;
  localparam int         QD       = 2;
  localparam int         CW       = 2;
  localparam int         W        = 10;
  localparam logic [3:0] RST_DIRS = 4'b0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scancode = 8'h00;
  logic       scancode_valid = 1'b0;
  logic       step = 1'b0;
  logic [3:0] direction;
  logic [3:0] queue_count;
  logic [1:0] turn_dropped;

  snake_dir_queue #(
    .NUM_PLAYERS(NP),
    .QUEUE_DEPTH(QD),
    .RESET_DIRS (RST_DIRS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .step          (step),
    .direction     (direction),
    .queue_count   (queue_count),
    .turn_dropped  (turn_dropped)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  string         cur_tag = "init";
  logic [W-1:0]  exp_q[$];

  logic [1:0] m_dir [2];
  logic [1:0] m_buf [2][QD];
  int         m_cnt [2];
  logic [1:0] m_drop;
  bit         m_ext;
  bit         m_brk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] bench_key(input int p, input bit ext, input logic [7:0] b);
    logic [2:0] r;
    r = 3'b000;
    if (ext) begin
`ifdef SNAKE_ARROW_KEYS_EN
      if (p == 0) begin
        if (b == 8'h75) r = 3'b100;
        if (b == 8'h74) r = 3'b101;
        if (b == 8'h72) r = 3'b110;
        if (b == 8'h6B) r = 3'b111;
      end
`endif
    end else if (p == 0) begin
      if (b == 8'h75) r = 3'b100;
      if (b == 8'h74) r = 3'b101;
      if (b == 8'h73) r = 3'b110;
      if (b == 8'h6B) r = 3'b111;
    end else begin
      if (b == 8'h1D) r = 3'b100;
      if (b == 8'h23) r = 3'b101;
      if (b == 8'h1B) r = 3'b110;
      if (b == 8'h1C) r = 3'b111;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [1:0] c0, c1;
    c0 = 2'(m_cnt[0]);
    c1 = 2'(m_cnt[1]);
    return {m_dir[1], m_dir[0], c1, c0, m_drop};
  endfunction

  task automatic model_reset();
    m_dir[0] = RST_DIRS[1:0];
    m_dir[1] = RST_DIRS[3:2];
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_drop   = 2'b00;
    m_ext    = 1'b0;
    m_brk    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] sc, input bit sv, input bit st);
    logic [2:0] k [2];
    logic [1:0] rd, opp;
    bit ok, popping, was_full;
    k[0] = 3'b000;
    k[1] = 3'b000;
    m_drop = 2'b00;
    if (sv) begin
      if (m_brk) begin
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else if (!m_ext && sc == 8'hE0) begin
        m_ext = 1'b1;
      end else if (sc == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        k[0] = bench_key(0, m_ext, sc);
        k[1] = bench_key(1, m_ext, sc);
        m_ext = 1'b0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      rd       = (m_cnt[p] > 0) ? m_buf[p][m_cnt[p]-1] : m_dir[p];
      opp      = rd + 2'd2;
      ok       = k[p][2] && (k[p][1:0] != rd) && (k[p][1:0] != opp);
      popping  = st && (m_cnt[p] > 0);
      was_full = (m_cnt[p] == QD);
      if (popping) begin
        m_dir[p] = m_buf[p][0];
        for (int i = 0; i < QD - 1; i++) m_buf[p][i] = m_buf[p][i+1];
        m_cnt[p]--;
      end
      if (ok) begin
        if (was_full && !popping) begin
          m_drop[p] = 1'b1;
        end else begin
          m_buf[p][m_cnt[p]] = k[p][1:0];
          m_cnt[p]++;
        end
      end
    end
  endtask

  // Called at a falling edge: drive, predict, then compare at the next falling edge.
  task automatic tick(input logic [7:0] sc, input bit sv, input bit st);
    scancode       = sc;
    scancode_valid = sv;
    step           = st;
    model_step(sc, sv, st);
    exp_q.push_back(model_outputs());
    @(negedge clk);
    check(cur_tag, 32'({direction, queue_count, turn_dropped}), 32'(exp_q.pop_front()));
  endtask

  task automatic key(input logic [7:0] sc);
    tick(sc, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    scancode_valid = 1'b0;
    step           = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #2;
    check({cur_tag, "_rst_dir"}, 32'(direction), 32'(RST_DIRS));
    check({cur_tag, "_rst_cnt"}, 32'(queue_count), 32'd0);
    check({cur_tag, "_rst_drop"}, 32'(turn_dropped), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  localparam int NBYTES = 13;
  logic [7:0] byte_tbl [NBYTES] = '{8'h75, 8'h74, 8'h73, 8'h6B, 8'h72, 8'h1D, 8'h23,
                                    8'h1B, 8'h1C, 8'hE0, 8'hF0, 8'h00, 8'h29};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    cur_tag = "por";
    check("por_dir", 32'(direction), 32'(RST_DIRS));
    check("por_cnt", 32'(queue_count), 32'd0);
    check("por_drop", 32'(turn_dropped), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    cur_tag = "rst_in_ext";
    key(8'h74);
    key(8'hE0);
    do_reset();
    key(8'h74);
    tick(8'h00, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "rst_in_brk";
    key(8'hF0);
    do_reset();
    key(8'h74);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "two_turns";
    do_reset();
    key(8'h74);
    key(8'h73);
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "reverse";
    do_reset();
    key(8'h73);
    key(8'h75);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "overflow";
    do_reset();
    key(8'h74);
    key(8'h73);
    key(8'h6B);
    tick(8'h00, 1'b0, 1'b0);

    cur_tag = "full_pop";
    key(8'h6B);
    tick(8'h6B, 1'b1, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "prefixes";
    do_reset();
    key(8'hF0); key(8'h74);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'hE0); key(8'h74);
    tick(8'h00, 1'b0, 1'b1);
    key(8'hE0); key(8'h72);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "two_player";
    do_reset();
    key(8'h1B);
    tick(8'h74, 1'b1, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    key(8'h1C);
    tick(8'h1D, 1'b1, 1'b1);
    tick(8'h00, 1'b0, 1'b1);

    cur_tag = "random";
    do_reset();
    for (int n = 0; n < 400; n++) begin
      tick(byte_tbl[$urandom_range(0, NBYTES - 1)],
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
Parametrised successor to the single-player direction decoder. Parses the raw PS/2 byte stream, including 0xE0 extended prefixes and 0xF0 break prefixes, and maps make codes to per-player directions. Each player has a small FIFO of pending turns, so fast key sequences within one game step are not lost. One queued turn is applied per game-step pulse. Sits between the PS/2 receiver and the snake movement/game-logic block.

Parameters:
NUM_PLAYERS, 1, number of players (1 or 2); player 0 = keypad 8/6/5/4, player 1 = W/D/S/A.
QUEUE_DEPTH, 2, turns buffered per player (1..8).
RESET_DIRS, 0, packed 2*NUM_PLAYERS-bit reset direction per player; player p uses bits [2p+1:2p].

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
scancode  input  8  PS/2 byte
scancode_valid  input  1  one-cycle strobe, scancode valid
step  input  1  one-cycle game-tick pulse
direction  output  2*NUM_PLAYERS  current direction per player (00 Up, 01 Right, 10 Down, 11 Left)
queue_count  output  NUM_PLAYERS*CW  per-player FIFO occupancy, CW = $clog2(QUEUE_DEPTH+1)
turn_dropped  output  NUM_PLAYERS  one-cycle pulse, accepted-key turn discarded because the FIFO was full

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - parser goes to IDLE
  - all FIFOs empty, queue_count = 0
  - direction = RESET_DIRS
  - turn_dropped = 0
- Parser FSM advances only on scancode_valid:
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; other byte -> decode as normal make code.
  - BRK: consume byte (release, ignored) -> IDLE.
  - EXT: 0xF0 -> EXT_BRK; other byte -> extended make (see optional feature) -> IDLE.
  - EXT_BRK: consume byte -> IDLE.
- Keymaps:
  - Player 0: 0x75 Up, 0x74 Right, 0x73 Down, 0x6B Left.
  - Player 1 (if NUM_PLAYERS=2): 0x1D Up, 0x23 Right, 0x1B Down, 0x1C Left.
  - Unmapped codes are ignored.
- Candidate filter, per player. Reference direction = FIFO tail entry if FIFO is non-empty, else the current direction. A candidate is rejected silently (no drop pulse) if it equals the reference or is its 180° opposite.
- Push: a filtered candidate is written at the FIFO tail in the cycle after the scancode strobe. If the FIFO is full, the candidate is discarded and turn_dropped[p] pulses for 1 cycle.
- Pop: on step, each non-empty FIFO pops its head into direction[p]; the update is visible the next cycle. An empty FIFO holds direction.
- Simultaneous push and pop in one cycle:
  - Both occur; occupancy is unchanged.
  - The filter uses the pre-pop tail.
  - A full FIFO with a simultaneous pop accepts the push (no drop).
  - On an empty FIFO, the pushed entry is not popped by the same step; it is applied at the next step.
- Pointers wrap modulo QUEUE_DEPTH. queue_count is a registered output, exact, saturating at QUEUE_DEPTH.
- Latency: scancode strobe to queue_count update is 1 cycle. Step to direction update is 1 cycle.

Optional Feature:
SNAKE_ARROW_KEYS_EN
- Defined: extended make codes E0 75/74/72/6B (arrow Up/Right/Down/Left) map to player 0 with the same filtering.
- Undefined: all E0-prefixed make codes are consumed and ignored. Keypad codes are unaffected either way.

Decomposition:
- Package snake_dir_pkg:
  - direction localparams UP/RIGHT/DOWN/LEFT and 2-bit dir type
  - PS/2 prefix constants 0xE0/0xF0
  - per-player scancode constants
  - opposite() function: XOR with 2'b10
- Sub-module snake_dir_fifo: one per player via generate. It holds storage, pointers, count, the tail-based filter and the drop pulse. The top holds the parser FSM and keymap decode.

Test Plan:
- rst pulse during EXT state, then byte 0x74 -> decoded as plain make; direction[1:0]=00 until step, Right after step.
- From Up: 0x74, 0x73, then step, step -> direction Right after the first step, Down after the second; queue_count 2 -> 1 -> 0.
- From Up, 0x73 alone -> rejected as reverse; queue_count stays 0, no drop, direction stays Up after step.
- QUEUE_DEPTH=2, from Up: 0x74, 0x73, 0x6B -> third turn dropped, turn_dropped[0] 1-cycle pulse, queue_count=2.
- F0 74 and E0 F0 75 sequences -> no FIFO change. With SNAKE_ARROW_KEYS_EN, E0 74 queues Right; without it, it is ignored.
- NUM_PLAYERS=2: 0x1B and 0x74 interleaved with step on the same cycle as a push -> each player updates independently; the same-cycle push is applied on the following step.
